// File: rtl/opamp_array_sync.sv
// rtl/opamp_array_sync.sv - clocked multi-channel op-amp / hysteretic comparator with rail clamp and slew limit
// Stages: S1 input difference, S2 gain or compare into a clamped target, S3 slew-limited complementary outputs.
module opamp_array_sync #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 12,
  parameter int GAIN_SHIFT = 2,
  parameter int SLEW_MAX   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         mode,
  input  logic [WIDTH-1:0]             rail_plus,
  input  logic [WIDTH-1:0]             rail_minus,
  input  logic [WIDTH-1:0]             hyst,
  input  logic [CHANNELS*WIDTH-1:0]    input_plus,
  input  logic [CHANNELS*WIDTH-1:0]    input_minus,
  output logic                         out_valid,
  output logic [CHANNELS*WIDTH-1:0]    output_plus,
  output logic [CHANNELS*WIDTH-1:0]    output_minus,
  output logic [CHANNELS-1:0]          sat
);

  localparam int DW = WIDTH + 1;
  localparam int TW = DW + GAIN_SHIFT;
  localparam int CW = WIDTH + 2;
  localparam logic signed [DW-1:0] SLEW    = DW'(SLEW_MAX);
  localparam logic signed [CW-1:0] OUT_MAX = CW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [CW-1:0] OUT_MIN = CW'(-(1 << (WIDTH - 1)));

  logic signed [WIDTH-1:0] rp;
  logic signed [WIDTH-1:0] rm;
  logic                    rails_inverted;

  logic v1;
  logic v2;
  logic signed [DW-1:0]    diff_d   [CHANNELS];
  logic signed [DW-1:0]    diff_q   [CHANNELS];
  logic signed [WIDTH-1:0] target_d [CHANNELS];
  logic signed [WIDTH-1:0] target_q [CHANNELS];
  logic [CHANNELS-1:0]     clamp_d;
  logic [CHANNELS-1:0]     clamp_q;
  logic [CHANNELS-1:0]     cmp_d;
  logic [CHANNELS-1:0]     cmp_q;
  logic signed [WIDTH-1:0] outp_d   [CHANNELS];
  logic signed [WIDTH-1:0] outp_q   [CHANNELS];
  logic signed [WIDTH-1:0] outm_d   [CHANNELS];
  logic signed [WIDTH-1:0] outm_q   [CHANNELS];
  logic [CHANNELS-1:0]     sat_q;

  assign rp = rail_plus;
  assign rm = rail_minus;
  // With crossed rails the upper bound takes precedence everywhere.
  assign rails_inverted = (rm > rp);

  // S1: exact difference, one extra bit so it never wraps
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      diff_d[c] = {input_plus[c*WIDTH + WIDTH - 1], input_plus[c*WIDTH +: WIDTH]}
                - {input_minus[c*WIDTH + WIDTH - 1], input_minus[c*WIDTH +: WIDTH]};
    end
  end

  // S2: linear gain with clamp, or comparator with hysteresis
  logic signed [TW-1:0] gain_t;
  logic signed [TW-1:0] rp_t;
  logic signed [TW-1:0] rm_t;
  logic signed [CW-1:0] diff_c;
  logic signed [CW-1:0] hyst_c;
  logic                 cmp_next;

  always_comb begin
    rp_t     = {{(TW-WIDTH){rail_plus[WIDTH-1]}}, rail_plus};
    rm_t     = {{(TW-WIDTH){rail_minus[WIDTH-1]}}, rail_minus};
    hyst_c   = {2'b00, hyst};
    gain_t   = '0;
    diff_c   = '0;
    cmp_next = 1'b0;
    cmp_d    = cmp_q;
    clamp_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      target_d[c] = '0;
      gain_t = {{(TW-DW){diff_q[c][DW-1]}}, diff_q[c]};
      gain_t = gain_t <<< GAIN_SHIFT;
      diff_c = {diff_q[c][DW-1], diff_q[c]};
      cmp_next = cmp_q[c];
      if (diff_c > hyst_c) begin
        cmp_next = 1'b1;
      end else if (diff_c < -hyst_c) begin
        cmp_next = 1'b0;
      end
      if (v1 && mode) begin
        cmp_d[c] = cmp_next;
      end
      if (mode) begin
        target_d[c] = cmp_next ? rp : rm;
        clamp_d[c]  = 1'b0;
      end else if (rails_inverted || (gain_t > rp_t)) begin
        target_d[c] = rp;
        clamp_d[c]  = 1'b1;
      end else if (gain_t < rm_t) begin
        target_d[c] = rm;
        clamp_d[c]  = 1'b1;
      end else begin
        target_d[c] = gain_t[WIDTH-1:0];
        clamp_d[c]  = 1'b0;
      end
    end
  end

  // S3: bounded step toward target, re-clamp, mirror about rail midpoint
  logic signed [DW-1:0] rp_w;
  logic signed [DW-1:0] rm_w;
  logic signed [DW-1:0] tgt_w;
  logic signed [DW-1:0] cur_w;
  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] stepped;
  logic signed [CW-1:0] minus_w;

  always_comb begin
    rp_w    = {rail_plus[WIDTH-1], rail_plus};
    rm_w    = {rail_minus[WIDTH-1], rail_minus};
    tgt_w   = '0;
    cur_w   = '0;
    delta   = '0;
    stepped = '0;
    minus_w = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tgt_w = {target_q[c][WIDTH-1], target_q[c]};
      cur_w = {outp_q[c][WIDTH-1], outp_q[c]};
      delta = tgt_w - cur_w;
      if (delta > SLEW) begin
        stepped = cur_w + SLEW;
      end else if (delta < -SLEW) begin
        stepped = cur_w - SLEW;
      end else begin
        stepped = tgt_w;
      end
      if (rails_inverted || (stepped > rp_w)) begin
        outp_d[c] = rp;
      end else if (stepped < rm_w) begin
        outp_d[c] = rm;
      end else begin
        outp_d[c] = stepped[WIDTH-1:0];
      end
      minus_w = {{2{rail_plus[WIDTH-1]}}, rail_plus}
              + {{2{rail_minus[WIDTH-1]}}, rail_minus}
              - {{2{outp_d[c][WIDTH-1]}}, outp_d[c]};
      if (minus_w > OUT_MAX) begin
        outm_d[c] = OUT_MAX[WIDTH-1:0];
      end else if (minus_w < OUT_MIN) begin
        outm_d[c] = OUT_MIN[WIDTH-1:0];
      end else begin
        outm_d[c] = minus_w[WIDTH-1:0];
      end
    end
  end

  // Bubbles leave every data register untouched; only the valid chain moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      cmp_q     <= '0;
      clamp_q   <= '0;
      sat_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        diff_q[c]   <= '0;
        target_q[c] <= '0;
        outp_q[c]   <= '0;
        outm_q[c]   <= '0;
      end
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      cmp_q     <= cmp_d;
      if (in_valid) begin
        for (int c = 0; c < CHANNELS; c++) begin
          diff_q[c] <= diff_d[c];
        end
      end
      if (v1) begin
        clamp_q <= clamp_d;
        for (int c = 0; c < CHANNELS; c++) begin
          target_q[c] <= target_d[c];
        end
      end
      if (v2) begin
        sat_q <= clamp_q;
        for (int c = 0; c < CHANNELS; c++) begin
          outp_q[c] <= outp_d[c];
          outm_q[c] <= outm_d[c];
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign output_plus[g*WIDTH +: WIDTH]  = outp_q[g];
    assign output_minus[g*WIDTH +: WIDTH] = outm_q[g];
  end

  assign sat = sat_q;

endmodule

// File: tb/tb_opamp_array_sync.sv
// tb/tb_opamp_array_sync.sv - self-checking bench for opamp_array_sync
// Directed vector tables, hand-written corner sequences and randomized traffic against a per-sample model.
module tb_opamp_array_sync;

  localparam int CH   = 4;
  localparam int W    = 12;
  localparam int GS   = 2;
  localparam int SLEW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            mode;
  logic [W-1:0]    rail_plus;
  logic [W-1:0]    rail_minus;
  logic [W-1:0]    hyst;
  logic [CH*W-1:0] input_plus;
  logic [CH*W-1:0] input_minus;
  logic            out_valid;
  logic [CH*W-1:0] output_plus;
  logic [CH*W-1:0] output_minus;
  logic [CH-1:0]   sat;

  opamp_array_sync #(
    .CHANNELS(CH), .WIDTH(W), .GAIN_SHIFT(GS), .SLEW_MAX(SLEW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .rail_plus(rail_plus), .rail_minus(rail_minus), .hyst(hyst),
    .input_plus(input_plus), .input_minus(input_minus),
    .out_valid(out_valid), .output_plus(output_plus),
    .output_minus(output_minus), .sat(sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus state
  int drv_p[CH];
  int drv_m[CH];
  int rp_i = 1000;
  int rm_i = -1000;
  int hy_i = 50;
  bit mode_b = 1'b0;

  // Reference model: two in-flight slots, then per-channel output state
  bit dl_v[2];
  bit dl_md[2];
  int dl_rp[2];
  int dl_rm[2];
  int dl_hy[2];
  int dl_d[2][CH];
  int m_op[CH];
  int m_om[CH];
  bit m_sat[CH];
  bit m_st[CH];
  bit m_ov;

  typedef struct {
    int ch;
    int ip;
    int im;
    bit md;
    int ep;
    int em;
    bit es;
  } vec_t;

  vec_t vt[24];

  function automatic int sx(input logic [W-1:0] x);
    return int'(signed'(x));
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d want %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) dl_v[k] = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_op[c]  = 0;
      m_om[c]  = 0;
      m_sat[c] = 1'b0;
      m_st[c]  = 1'b0;
    end
    m_ov = 1'b0;
  endtask

  task automatic model_apply();
    int d, t, tgt, o, om, stp;
    bit s;
    for (int c = 0; c < CH; c++) begin
      d = dl_d[1][c];
      if (dl_md[1]) begin
        if (d > dl_hy[1]) m_st[c] = 1'b1;
        else if (d < -dl_hy[1]) m_st[c] = 1'b0;
        tgt = m_st[c] ? dl_rp[1] : dl_rm[1];
        s = 1'b0;
      end else begin
        t = d * (2 ** GS);
        s = 1'b1;
        if (dl_rm[1] > dl_rp[1] || t > dl_rp[1]) tgt = dl_rp[1];
        else if (t < dl_rm[1]) tgt = dl_rm[1];
        else begin
          tgt = t;
          s = 1'b0;
        end
      end
      stp = tgt - m_op[c];
      if (stp > SLEW) stp = SLEW;
      else if (stp < -SLEW) stp = -SLEW;
      o = m_op[c] + stp;
      if (dl_rm[1] > dl_rp[1] || o > dl_rp[1]) o = dl_rp[1];
      else if (o < dl_rm[1]) o = dl_rm[1];
      om = dl_rp[1] + dl_rm[1] - o;
      if (om > 2047) om = 2047;
      else if (om < -2048) om = -2048;
      m_op[c]  = o;
      m_om[c]  = om;
      m_sat[c] = s;
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 0, int'(out_valid), int'(m_ov));
    for (int c = 0; c < CH; c++) begin
      chk("output_plus", c, sx(output_plus[c*W +: W]), m_op[c]);
      chk("output_minus", c, sx(output_minus[c*W +: W]), m_om[c]);
      chk("sat", c, int'(sat[c]), int'(m_sat[c]));
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare 1 ns later.
  task automatic cycle(input bit v);
    in_valid   = v;
    mode       = mode_b;
    rail_plus  = W'(rp_i);
    rail_minus = W'(rm_i);
    hyst       = W'(hy_i);
    for (int c = 0; c < CH; c++) begin
      input_plus[c*W +: W]  = W'(drv_p[c]);
      input_minus[c*W +: W] = W'(drv_m[c]);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_ov = dl_v[1];
      if (dl_v[1]) model_apply();
      dl_v[1]  = dl_v[0];
      dl_md[1] = dl_md[0];
      dl_rp[1] = dl_rp[0];
      dl_rm[1] = dl_rm[0];
      dl_hy[1] = dl_hy[0];
      for (int c = 0; c < CH; c++) dl_d[1][c] = dl_d[0][c];
      dl_v[0]  = v;
      dl_md[0] = mode_b;
      dl_rp[0] = rp_i;
      dl_rm[0] = rm_i;
      dl_hy[0] = hy_i;
      for (int c = 0; c < CH; c++) dl_d[0][c] = drv_p[c] - drv_m[c];
    end
    #1;
    compare_all();
  endtask

  task automatic clear_drv();
    for (int c = 0; c < CH; c++) begin
      drv_p[c] = 0;
      drv_m[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < CH; c++) begin
        drv_p[c] = int'($urandom_range(0, 4095)) - 2048;
        drv_m[c] = int'($urandom_range(0, 4095)) - 2048;
      end
      cycle($urandom_range(0, 1) == 1);
    end
    rst = 1'b0;
    clear_drv();
  endtask

  task automatic run_table(input int lo, input int hi);
    int j;
    do_reset();
    mode_b = vt[lo].md;
    for (int i = lo; i <= hi + 2; i++) begin
      clear_drv();
      if (i <= hi) begin
        drv_p[vt[i].ch] = vt[i].ip;
        drv_m[vt[i].ch] = vt[i].im;
        cycle(1'b1);
      end else begin
        cycle(1'b0);
      end
      if (i == lo + 1) chk("tbl_latency_pre", lo, int'(out_valid), 0);
      if (i >= lo + 2) begin
        j = i - 2;
        chk("tbl_valid", j, int'(out_valid), 1);
        chk("tbl_plus", j, sx(output_plus[vt[j].ch*W +: W]), vt[j].ep);
        chk("tbl_minus", j, sx(output_minus[vt[j].ch*W +: W]), vt[j].em);
        chk("tbl_sat", j, int'(sat[vt[j].ch]), int'(vt[j].es));
      end
    end
    mode_b = 1'b0;
  endtask

  int gexp[4] = '{64, 128, 160, 160};
  int gn;
  int gprev;

  task automatic gap_observe();
    if (out_valid) begin
      chk("gap_step", gn, sx(output_plus[0 +: W]), (gn < 4) ? gexp[gn] : -9999);
      gn++;
    end else begin
      chk("gap_hold", gn, sx(output_plus[0 +: W]), gprev);
    end
    gprev = sx(output_plus[0 +: W]);
  endtask

  initial begin
    int ep;
    // Table: linear slew on ch0, comparator on ch2, saturation ramp on ch1
    vt[0] = '{0, 100, 60, 1'b0,   64,  -64, 1'b0};
    vt[1] = '{0, 100, 60, 1'b0,  128, -128, 1'b0};
    vt[2] = '{0, 100, 60, 1'b0,  160, -160, 1'b0};
    vt[3] = '{0, 100, 60, 1'b0,  160, -160, 1'b0};
    vt[4] = '{2,  40,  0, 1'b1,  -64,   64, 1'b0};
    vt[5] = '{2,  60,  0, 1'b1,    0,    0, 1'b0};
    vt[6] = '{2,   0, 40, 1'b1,   64,  -64, 1'b0};
    vt[7] = '{2,   0, 60, 1'b1,    0,    0, 1'b0};
    for (int k = 1; k <= 16; k++) begin
      ep = (64 * k > 1000) ? 1000 : 64 * k;
      vt[7 + k] = '{1, 500, 0, 1'b0, ep, -ep, 1'b1};
    end

    rst = 1'b1;
    in_valid = 1'b0;
    clear_drv();
    model_reset();

    // Reset with random inputs
    do_reset();
    chk("reset_out_valid", 0, int'(out_valid), 0);
    for (int c = 0; c < CH; c++) begin
      chk("reset_plus", c, sx(output_plus[c*W +: W]), 0);
      chk("reset_minus", c, sx(output_minus[c*W +: W]), 0);
      chk("reset_sat", c, int'(sat[c]), 0);
    end

    run_table(0, 3);
    run_table(4, 7);
    run_table(8, 23);

    // Bubbles inside the linear ramp: same steps, held outputs in gaps
    do_reset();
    gn = 0;
    gprev = 0;
    drv_p[0] = 100;
    drv_m[0] = 60;
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1);
      gap_observe();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        cycle(1'b0);
        gap_observe();
      end
    end
    for (int g = 0; g < 4; g++) begin
      cycle(1'b0);
      gap_observe();
    end
    chk("gap_count", 0, gn, 4);

    // Reset in the middle of a ramp discards in-flight samples
    do_reset();
    drv_p[1] = 500;
    for (int s = 0; s < 5; s++) cycle(1'b1);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    chk("midrst_plus", 1, sx(output_plus[W +: W]), 0);
    chk("midrst_valid", 0, int'(out_valid), 0);
    clear_drv();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0);
      chk("stale_valid", k, int'(out_valid), 0);
    end

    // Opposite ramps on ch0/ch3, then crossed rails
    do_reset();
    drv_p[0] = 300;
    drv_m[3] = 300;
    for (int s = 0; s < 3; s++) cycle(1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0);
    chk("indep_plus", 0, sx(output_plus[0 +: W]), 192);
    chk("indep_plus", 3, sx(output_plus[3*W +: W]), -192);
    chk("indep_sat", 0, int'(sat), 4'b1001);
    rp_i = 100;
    rm_i = 200;
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    for (int c = 0; c < CH; c++) begin
      chk("inv_plus", c, sx(output_plus[c*W +: W]), 100);
      chk("inv_minus", c, sx(output_minus[c*W +: W]), 200);
    end
    chk("inv_sat", 0, int'(sat), 4'b1111);

    // Randomized phases; mode/rails/hyst change only with the pipe drained
    for (int ph = 0; ph < 16; ph++) begin
      if (ph % 4 == 0) do_reset();
      mode_b = ($urandom_range(0, 1) == 1);
      hy_i   = int'($urandom_range(0, 300));
      rp_i   = int'($urandom_range(0, 4095)) - 2048;
      rm_i   = int'($urandom_range(0, 4095)) - 2048;
      if ((ph % 5 != 3) && (rm_i > rp_i)) begin
        ep   = rp_i;
        rp_i = rm_i;
        rm_i = ep;
      end
      for (int k = 0; k < 40; k++) begin
        for (int c = 0; c < CH; c++) begin
          if (mode_b) begin
            drv_p[c] = int'($urandom_range(0, 800)) - 400;
            drv_m[c] = int'($urandom_range(0, 100)) - 50;
          end else begin
            drv_p[c] = int'($urandom_range(0, 4095)) - 2048;
            drv_m[c] = int'($urandom_range(0, 4095)) - 2048;
          end
        end
        cycle($urandom_range(0, 3) != 0);
      end
      clear_drv();
      for (int k = 0; k < 3; k++) cycle(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
